// File: rtl/replace_pkg.sv
// rtl/replace_pkg.sv - shared types and helpers for the replacement-interface controller
package replace_pkg;

  localparam int MAX_WAYS = 64;

  typedef enum logic [1:0] {
    IDLE,
    QUERY,
    WAIT,
    RESP
  } state_t;

  // Index width of an n-entry space; a single entry still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Priority encoder: index of the lowest clear bit among the first n; 0 when none are clear.
  function automatic int lowest_zero(input logic [MAX_WAYS-1:0] vmask, input int n);
    int pick;
    pick = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (i < n && !vmask[i]) pick = i;
    end
    return pick;
  endfunction

endpackage

// File: rtl/replace_hit_skid.sv
// rtl/replace_hit_skid.sv - one-entry skid holding a port-0 hit report displaced by an invalid-way touch
module replace_hit_skid
#(
  parameter type hit_t = logic
)
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  hit_t in_hit,
  input  logic blocked,
  output logic out_valid,
  output hit_t out_hit,
  output logic full
);

  hit_t held;

  // A held entry always issues before a newly arriving report, keeping port-0 order.
  assign out_valid = !blocked && (full || in_valid);
  assign out_hit   = full ? held : in_hit;

  // Capture a report only when the port is blocked; release the entry on the first free cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      held <= '0;
    end else if (!full && in_valid && blocked) begin
      full <= 1'b1;
      held <= in_hit;
    end else if (full && !blocked) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/replace_victim_ctrl.sv
// rtl/replace_victim_ctrl.sv - allocation-way picker driving the Replace unit hit and victim ports
module replace_victim_ctrl
  import replace_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int WAY_NUM    = 4,
  parameter int READ_PORT  = 1,
  parameter int WAY_WIDTH  = idx_width(WAY_NUM),
  parameter int ADDR_WIDTH = idx_width(DEPTH)
)
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [READ_PORT-1:0]            acc_valid,
  output logic [READ_PORT-1:0]            acc_ready,
  input  logic [READ_PORT*ADDR_WIDTH-1:0] acc_idx,
  input  logic [READ_PORT*WAY_WIDTH-1:0]  acc_way,
  input  logic                            alloc_req_valid,
  output logic                            alloc_req_ready,
  input  logic [ADDR_WIDTH-1:0]           alloc_idx,
  input  logic [WAY_NUM-1:0]              alloc_vmask,
  output logic                            alloc_resp_valid,
  input  logic                            alloc_resp_ready,
  output logic [WAY_WIDTH-1:0]            alloc_resp_way,
  output logic [READ_PORT-1:0]            rep_hit_en,
  output logic [READ_PORT*ADDR_WIDTH-1:0] rep_hit_idx,
  output logic [READ_PORT*WAY_WIDTH-1:0]  rep_hit_way,
  output logic                            rep_miss_en,
  output logic [ADDR_WIDTH-1:0]           rep_miss_idx,
  input  logic [WAY_WIDTH-1:0]            rep_miss_way
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [WAY_WIDTH-1:0]  way;
  } hit_t;

  state_t               state;
  logic                 req_fire;
  logic                 set_full;
  logic                 touch;
  logic [WAY_WIDTH-1:0] free_way;
  logic                 skid_full;
  logic                 skid_valid;
  hit_t                 acc0_hit;
  hit_t                 skid_hit;

  assign alloc_req_ready = (state == IDLE);
  assign req_fire        = alloc_req_valid && (state == IDLE);
  // A direct-mapped cache never has a choice, so it never consults the policy.
  assign set_full        = (WAY_NUM > 1) && (&alloc_vmask);
  assign touch           = req_fire && !set_full;
  assign free_way        = WAY_WIDTH'(lowest_zero(MAX_WAYS'(alloc_vmask), WAY_NUM));
  assign acc0_hit.idx    = acc_idx[ADDR_WIDTH-1:0];
  assign acc0_hit.way    = acc_way[WAY_WIDTH-1:0];

  // Only port 0 can be blocked (by the invalid-way touch); the rest always accept.
  always_comb begin
    acc_ready    = '1;
    acc_ready[0] = !skid_full;
  end

  replace_hit_skid #(.hit_t(hit_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc_valid[0] && !skid_full),
    .in_hit    (acc0_hit),
    .blocked   (touch),
    .out_valid (skid_valid),
    .out_hit   (skid_hit),
    .full      (skid_full)
  );

  // Allocation FSM: invalid way answers next cycle; a full set asks Replace and waits for its victim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      alloc_resp_valid <= 1'b0;
      alloc_resp_way   <= '0;
      rep_miss_en      <= 1'b0;
      rep_miss_idx     <= '0;
    end else begin
      rep_miss_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            if (set_full) begin
              state        <= QUERY;
              rep_miss_en  <= 1'b1;
              rep_miss_idx <= alloc_idx;
            end else begin
              state            <= RESP;
              alloc_resp_valid <= 1'b1;
              alloc_resp_way   <= free_way;
            end
          end
        end
        QUERY: state <= WAIT;
        WAIT: begin
          state            <= RESP;
          alloc_resp_valid <= 1'b1;
          alloc_resp_way   <= rep_miss_way;
        end
        RESP: begin
          if (alloc_resp_ready) begin
            state            <= IDLE;
            alloc_resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered hit reports: port 0 carries the MRU touch first, then skid/new traffic; others pass through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_hit_en  <= '0;
      rep_hit_idx <= '0;
      rep_hit_way <= '0;
    end else begin
      rep_hit_en[0]                <= touch || skid_valid;
      rep_hit_idx[ADDR_WIDTH-1:0]  <= touch ? alloc_idx : skid_hit.idx;
      rep_hit_way[WAY_WIDTH-1:0]   <= touch ? free_way : skid_hit.way;
      for (int p = 1; p < READ_PORT; p++) begin
        rep_hit_en[p]                          <= acc_valid[p];
        rep_hit_idx[p*ADDR_WIDTH +: ADDR_WIDTH] <= acc_idx[p*ADDR_WIDTH +: ADDR_WIDTH];
        rep_hit_way[p*WAY_WIDTH +: WAY_WIDTH]   <= acc_way[p*WAY_WIDTH +: WAY_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_replace_victim_ctrl.sv
// tb/tb_replace_victim_ctrl.sv - self-checking bench for replace_victim_ctrl
module tb_replace_victim_ctrl;

  localparam int WAY_NUM = 4;
  localparam int RP      = 1;
  localparam int AW      = 8;
  localparam int WW      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [RP-1:0]     acc_valid;
  logic [RP-1:0]     acc_ready;
  logic [RP*AW-1:0]  acc_idx;
  logic [RP*WW-1:0]  acc_way;
  logic              alloc_req_valid;
  logic              alloc_req_ready;
  logic [AW-1:0]     alloc_idx;
  logic [WAY_NUM-1:0] alloc_vmask;
  logic              alloc_resp_valid;
  logic              alloc_resp_ready;
  logic [WW-1:0]     alloc_resp_way;
  logic [RP-1:0]     rep_hit_en;
  logic [RP*AW-1:0]  rep_hit_idx;
  logic [RP*WW-1:0]  rep_hit_way;
  logic              rep_miss_en;
  logic [AW-1:0]     rep_miss_idx;
  logic [WW-1:0]     rep_miss_way;

  int vectors = 0;
  int miscompares = 0;

  replace_victim_ctrl dut (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_idx(acc_idx), .acc_way(acc_way),
    .alloc_req_valid(alloc_req_valid), .alloc_req_ready(alloc_req_ready),
    .alloc_idx(alloc_idx), .alloc_vmask(alloc_vmask),
    .alloc_resp_valid(alloc_resp_valid), .alloc_resp_ready(alloc_resp_ready),
    .alloc_resp_way(alloc_resp_way),
    .rep_hit_en(rep_hit_en), .rep_hit_idx(rep_hit_idx), .rep_hit_way(rep_hit_way),
    .rep_miss_en(rep_miss_en), .rep_miss_idx(rep_miss_idx), .rep_miss_way(rep_miss_way)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the allocator prefers the lowest-numbered invalid way; -1 when every way is valid.
  function automatic int first_free(input logic [WAY_NUM-1:0] m);
    int w;
    w = -1;
    for (int i = WAY_NUM - 1; i >= 0; i--) if (!m[i]) w = i;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    acc_valid = '0; acc_idx = '0; acc_way = '0;
    alloc_req_valid = 1'b0; alloc_idx = '0; alloc_vmask = '0;
    alloc_resp_ready = 1'b0; rep_miss_way = '0;
    tick(); tick();
    vectors++;
    if ({rep_hit_en, rep_hit_idx, rep_hit_way, rep_miss_en, rep_miss_idx} !== '0) begin
      miscompares++; $display("FAIL reset_rep: got %0h expected 0", {rep_hit_en, rep_hit_idx, rep_hit_way, rep_miss_en, rep_miss_idx});
    end
    vectors++;
    if (alloc_req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %0b expected 1", alloc_req_ready); end
    vectors++;
    if (acc_ready !== '1) begin miscompares++; $display("FAIL reset_acc_ready: got %0b expected 1", acc_ready); end
    vectors++;
    if ({alloc_resp_valid, alloc_resp_way} !== '0) begin
      miscompares++; $display("FAIL reset_resp: got %0h expected 0", {alloc_resp_valid, alloc_resp_way});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_hit_forward();
    logic          v;
    logic [AW-1:0] i;
    logic [WW-1:0] w;
    acc_valid = 1'b1; acc_idx = 8'd5; acc_way = 2'd2;
    tick();
    acc_valid = 1'b0;
    vectors++;
    if ({rep_hit_en, rep_hit_idx, rep_hit_way} !== {1'b1, 8'd5, 2'd2}) begin
      miscompares++; $display("FAIL hit_fwd: got en=%0b idx=%0d way=%0d expected en=1 idx=5 way=2", rep_hit_en, rep_hit_idx, rep_hit_way);
    end
    tick();
    vectors++;
    if (rep_hit_en !== 1'b0) begin miscompares++; $display("FAIL hit_fwd_pulse: got en=%0b expected 0", rep_hit_en); end
    for (int k = 0; k < 16; k++) begin
      v = 1'($urandom); i = AW'($urandom); w = WW'($urandom);
      acc_valid = v; acc_idx = i; acc_way = w;
      tick();
      vectors++;
      if (rep_hit_en !== v || (v && {rep_hit_idx, rep_hit_way} !== {i, w})) begin
        miscompares++; $display("FAIL hit_fwd_rand: got en=%0b idx=%0d way=%0d expected en=%0b idx=%0d way=%0d", rep_hit_en, rep_hit_idx, rep_hit_way, v, i, w);
      end
    end
    acc_valid = 1'b0;
    tick();
  endtask

  task automatic do_invalid_alloc(input logic [AW-1:0] idx, input logic [WAY_NUM-1:0] vm);
    logic [WW-1:0] ew;
    ew = WW'(first_free(vm));
    alloc_req_valid = 1'b1; alloc_idx = idx; alloc_vmask = vm;
    tick();
    alloc_req_valid = 1'b0;
    vectors++;
    if ({alloc_resp_valid, alloc_resp_way} !== {1'b1, ew}) begin
      miscompares++; $display("FAIL inv_resp: got valid=%0b way=%0d expected valid=1 way=%0d", alloc_resp_valid, alloc_resp_way, ew);
    end
    vectors++;
    if ({rep_hit_en, rep_hit_idx, rep_hit_way} !== {1'b1, idx, ew}) begin
      miscompares++; $display("FAIL inv_touch: got en=%0b idx=%0d way=%0d expected en=1 idx=%0d way=%0d", rep_hit_en, rep_hit_idx, rep_hit_way, idx, ew);
    end
    vectors++;
    if ({alloc_req_ready, rep_miss_en} !== 2'b00) begin
      miscompares++; $display("FAIL inv_busy: got ready=%0b miss=%0b expected 0 0", alloc_req_ready, rep_miss_en);
    end
    alloc_resp_ready = 1'b1;
    tick();
    alloc_resp_ready = 1'b0;
    vectors++;
    if ({alloc_resp_valid, alloc_req_ready, rep_hit_en} !== 3'b010) begin
      miscompares++; $display("FAIL inv_done: got valid=%0b ready=%0b hit=%0b expected 0 1 0", alloc_resp_valid, alloc_req_ready, rep_hit_en);
    end
  endtask

  task automatic test_invalid_alloc();
    logic [WAY_NUM-1:0] vm;
    do_invalid_alloc(8'd9, 4'b1011);
    for (int k = 0; k < 6; k++) begin
      vm = WAY_NUM'($urandom);
      if (vm == '1) vm[$urandom_range(0, WAY_NUM - 1)] = 1'b0;
      do_invalid_alloc(AW'($urandom), vm);
    end
  endtask

  // Full-set request; leaves the DUT holding the response with alloc_resp_ready low.
  task automatic do_full_alloc(input logic [AW-1:0] idx, input logic [WW-1:0] victim);
    alloc_req_valid = 1'b1; alloc_idx = idx; alloc_vmask = '1;
    tick();
    alloc_req_valid = 1'b0;
    vectors++;
    if ({rep_miss_en, rep_miss_idx, alloc_resp_valid, alloc_req_ready} !== {1'b1, idx, 2'b00}) begin
      miscompares++; $display("FAIL full_miss: got miss=%0b idx=%0d valid=%0b ready=%0b expected 1 %0d 0 0", rep_miss_en, rep_miss_idx, alloc_resp_valid, alloc_req_ready, idx);
    end
    tick();
    rep_miss_way = victim;
    vectors++;
    if ({rep_miss_en, alloc_resp_valid} !== 2'b00) begin
      miscompares++; $display("FAIL full_wait: got miss=%0b valid=%0b expected 0 0", rep_miss_en, alloc_resp_valid);
    end
    tick();
    rep_miss_way = ~victim;
    vectors++;
    if ({alloc_resp_valid, alloc_resp_way} !== {1'b1, victim}) begin
      miscompares++; $display("FAIL full_resp: got valid=%0b way=%0d expected valid=1 way=%0d", alloc_resp_valid, alloc_resp_way, victim);
    end
  endtask

  task automatic finish_resp();
    alloc_resp_ready = 1'b1;
    tick();
    alloc_resp_ready = 1'b0;
    vectors++;
    if ({alloc_resp_valid, alloc_req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL resp_release: got valid=%0b ready=%0b expected 0 1", alloc_resp_valid, alloc_req_ready);
    end
  endtask

  task automatic test_full_alloc();
    do_full_alloc(8'd3, 2'd1);
    finish_resp();
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] v;
    v = WW'($urandom);
    do_full_alloc(AW'($urandom), v);
    for (int k = 0; k < 5; k++) begin
      rep_miss_way = WW'($urandom);
      tick();
      vectors++;
      if ({alloc_resp_valid, alloc_resp_way, alloc_req_ready} !== {1'b1, v, 1'b0}) begin
        miscompares++; $display("FAIL backpressure: got valid=%0b way=%0d ready=%0b expected 1 %0d 0", alloc_resp_valid, alloc_resp_way, alloc_req_ready, v);
      end
    end
    finish_resp();
  endtask

  task automatic test_conflict();
    vectors++;
    if (acc_ready[0] !== 1'b1) begin miscompares++; $display("FAIL conflict_pre_ready: got %0b expected 1", acc_ready[0]); end
    alloc_req_valid = 1'b1; alloc_idx = 8'd20; alloc_vmask = 4'b0111;
    acc_valid = 1'b1; acc_idx = 8'd7; acc_way = 2'd0;
    tick();
    alloc_req_valid = 1'b0; acc_valid = 1'b0;
    vectors++;
    if ({rep_hit_en, rep_hit_idx, rep_hit_way, acc_ready[0]} !== {1'b1, 8'd20, 2'd3, 1'b0}) begin
      miscompares++; $display("FAIL conflict_touch: got en=%0b idx=%0d way=%0d rdy=%0b expected 1 20 3 0", rep_hit_en, rep_hit_idx, rep_hit_way, acc_ready[0]);
    end
    alloc_resp_ready = 1'b1;
    tick();
    alloc_resp_ready = 1'b0;
    vectors++;
    if ({rep_hit_en, rep_hit_idx, rep_hit_way, acc_ready[0]} !== {1'b1, 8'd7, 2'd0, 1'b1}) begin
      miscompares++; $display("FAIL conflict_skid: got en=%0b idx=%0d way=%0d rdy=%0b expected 1 7 0 1", rep_hit_en, rep_hit_idx, rep_hit_way, acc_ready[0]);
    end
    tick();
    vectors++;
    if (rep_hit_en !== 1'b0) begin miscompares++; $display("FAIL conflict_drain: got en=%0b expected 0", rep_hit_en); end
  endtask

  task automatic test_reset_mid_query();
    alloc_req_valid = 1'b1; alloc_idx = 8'd40; alloc_vmask = '1;
    tick();
    alloc_req_valid = 1'b0;
    vectors++;
    if (rep_miss_en !== 1'b1) begin miscompares++; $display("FAIL rstq_miss: got %0b expected 1", rep_miss_en); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({rep_hit_en, rep_miss_en, alloc_resp_valid, alloc_req_ready} !== 4'b0001) begin
      miscompares++; $display("FAIL rstq_async: got hit=%0b miss=%0b valid=%0b ready=%0b expected 0 0 0 1", rep_hit_en, rep_miss_en, alloc_resp_valid, alloc_req_ready);
    end
    #2 rst = 1'b0;
    rep_miss_way = 2'd2;
    alloc_resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if ({rep_hit_en, rep_miss_en, alloc_resp_valid, alloc_req_ready} !== 4'b0001) begin
        miscompares++; $display("FAIL rstq_after: got hit=%0b miss=%0b valid=%0b ready=%0b expected 0 0 0 1", rep_hit_en, rep_miss_en, alloc_resp_valid, alloc_req_ready);
      end
    end
    alloc_resp_ready = 1'b0;
  endtask

  // Transaction model: per-cycle expectations from accept timestamps plus an ordered port-0 hit stream.
  task automatic test_random();
    logic [AW+WW-1:0] hit_q[$];
    logic [AW+WW-1:0] exp_hit;
    int               miss_cyc = -1, victim_cyc = -1, resp_cyc = -1, f;
    logic             m_ready = 1'b1, m_resp_valid = 1'b0, m_block = 1'b0;
    logic [WW-1:0]    m_way = '0;
    logic             a_acc, h_acc, hs, quiet;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == resp_cyc) m_resp_valid = 1'b1;
      vectors++;
      if (alloc_req_ready !== m_ready) begin miscompares++; $display("FAIL rnd_req_ready c%0d: got %0b expected %0b", cyc, alloc_req_ready, m_ready); end
      vectors++;
      if (rep_miss_en !== (cyc == miss_cyc)) begin miscompares++; $display("FAIL rnd_miss_en c%0d: got %0b expected %0b", cyc, rep_miss_en, cyc == miss_cyc); end
      vectors++;
      if (alloc_resp_valid !== m_resp_valid || (m_resp_valid && alloc_resp_way !== m_way)) begin
        miscompares++; $display("FAIL rnd_resp c%0d: got valid=%0b way=%0d expected valid=%0b way=%0d", cyc, alloc_resp_valid, alloc_resp_way, m_resp_valid, m_way);
      end
      vectors++;
      if (acc_ready[0] !== !m_block) begin miscompares++; $display("FAIL rnd_acc_ready c%0d: got %0b expected %0b", cyc, acc_ready[0], !m_block); end
      if (rep_hit_en[0] === 1'b1) begin
        vectors++;
        if (hit_q.size() == 0) begin
          miscompares++; $display("FAIL rnd_hit_extra c%0d: got idx=%0d way=%0d expected none", cyc, rep_hit_idx, rep_hit_way);
        end else begin
          exp_hit = hit_q.pop_front();
          if ({rep_hit_idx, rep_hit_way} !== exp_hit) begin
            miscompares++; $display("FAIL rnd_hit c%0d: got %0h expected %0h", cyc, {rep_hit_idx, rep_hit_way}, exp_hit);
          end
        end
      end
      quiet = (cyc >= 390);
      rep_miss_way = WW'($urandom);
      if (cyc == victim_cyc) m_way = rep_miss_way;
      alloc_req_valid  = !quiet && ($urandom_range(0, 2) == 0);
      alloc_idx        = AW'($urandom);
      alloc_vmask      = ($urandom_range(0, 1) == 1) ? '1 : WAY_NUM'($urandom);
      alloc_resp_ready = quiet || ($urandom_range(0, 1) == 1);
      acc_valid        = !quiet && ($urandom_range(0, 1) == 1);
      acc_idx          = AW'($urandom);
      acc_way          = WW'($urandom);
      a_acc = alloc_req_valid && m_ready;
      h_acc = acc_valid[0] && !m_block;
      hs    = m_resp_valid && alloc_resp_ready;
      m_block = 1'b0;
      if (hs) begin m_resp_valid = 1'b0; m_ready = 1'b1; end
      if (a_acc) begin
        m_ready = 1'b0;
        f = first_free(alloc_vmask);
        if (f >= 0) begin
          m_way = WW'(f);
          resp_cyc = cyc + 1;
          hit_q.push_back({alloc_idx, WW'(f)});
          m_block = h_acc;
        end else begin
          miss_cyc = cyc + 1; victim_cyc = cyc + 2; resp_cyc = cyc + 3;
        end
      end
      if (h_acc) hit_q.push_back({acc_idx, acc_way});
      tick();
    end
    vectors++;
    if (hit_q.size() != 0) begin miscompares++; $display("FAIL rnd_hit_lost: got %0d pending expected 0", hit_q.size()); end
    alloc_resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit_forward();
    test_invalid_alloc();
    test_full_alloc();
    test_backpressure();
    test_conflict();
    test_reset_mid_query();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
